// File: rtl/mm_iddmm_arbiter_pkg.sv
// Shared types and helpers for the Montgomery-engine arbiter and the
// round-robin picker it uses.
package mm_iddmm_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    LOAD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int K_DEF = 128;
  localparam int N_DEF = 32;
  localparam int R_DEF = 2;

  // Widths for the default configuration; parameterised modules derive their own.
  localparam int CNT_W = $clog2(N_DEF + 1);
  localparam int OWN_W = $clog2(R_DEF);

  // Index that follows idx in a ring of r entries.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned r);
    return (idx + 1 >= r) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mm_iddmm_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first request found when searching
// ptr, ptr+1, ... mod R wins.
module rr_arbiter #(
  parameter int R     = 2,
  parameter int OWN_W = $clog2(R)
) (
  input  logic [R-1:0]     req,
  input  logic [OWN_W-1:0] ptr,
  output logic [R-1:0]     gnt,
  output logic [OWN_W-1:0] idx
);

  logic [OWN_W-1:0] cand [R];
  logic [R-1:0]     hit;

  genvar gi;
  generate
    for (gi = 0; gi < R; gi++) begin : g_cand
      assign cand[gi] = OWN_W'((int'(ptr) + gi) % R);
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  // Walk from the far end so the candidate nearest ptr is written last.
  always_comb begin
    idx = '0;
    for (int i = R - 1; i >= 0; i--) begin
      if (hit[i]) idx = cand[i];
    end
    gnt = (|hit) ? (R'(1) << idx) : '0;
  end

endmodule

// File: rtl/mm_iddmm_arbiter.sv
// Shares one mm_iddmm_top Montgomery engine between R requesters: one whole
// N-word operation per grant, results routed back to the owner.
module mm_iddmm_arbiter
  import mm_iddmm_arbiter_pkg::*;
#(
  parameter int K = K_DEF,
  parameter int N = N_DEF,
  parameter int R = R_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [R-1:0]          req_valid,
  output logic [R-1:0]          req_gnt,
  input  logic [R*K-1:0]        req_x,
  input  logic [R*K-1:0]        req_y,
  input  logic [R-1:0]          req_xy_valid,
  output logic [K-1:0]          rsp_data,
  output logic [R-1:0]          rsp_valid,
  output logic                  rsp_last,
  output logic                  busy,
  output logic [$clog2(R)-1:0]  owner,
  output logic                  err_stray,
  output logic                  mm_start,
  output logic [K-1:0]          mm_x,
  output logic                  mm_x_valid,
  output logic [K-1:0]          mm_y,
  output logic                  mm_y_valid,
  input  logic [K-1:0]          mm_result,
  input  logic                  mm_valid
);

  localparam int CW = $clog2(N + 1);
  localparam int OW = $clog2(R);
  localparam logic [CW-1:0] N_CNT = CW'(N);
  localparam logic [CW-1:0] N_M1  = CW'(N - 1);

  state_t          state_reg, state_next;
  logic [OW-1:0]   owner_reg, owner_next;
  logic [OW-1:0]   ptr_reg, ptr_next;
  logic [CW-1:0]   op_cnt_reg, op_cnt_next, op_cnt_inc;
  logic [CW-1:0]   rs_cnt_reg, rs_cnt_next, rs_cnt_inc;
  logic [R-1:0]    arb_gnt;
  logic [OW-1:0]   arb_idx;
  logic            accept, res_in, release_now, in_op;
  logic [K-1:0]    own_x, own_y;

  logic [R-1:0]    req_gnt_reg, req_gnt_next;
  logic [K-1:0]    rsp_data_reg, rsp_data_next;
  logic [R-1:0]    rsp_valid_reg, rsp_valid_next;
  logic            rsp_last_reg, rsp_last_next;
  logic            busy_reg, busy_next;
  logic            err_stray_reg, err_stray_next;
  logic            mm_start_reg, mm_start_next;
  logic [K-1:0]    mm_x_reg, mm_x_next;
  logic [K-1:0]    mm_y_reg, mm_y_next;
  logic            xy_valid_reg, xy_valid_next;

  rr_arbiter #(
    .R     (R),
    .OWN_W (OW)
  ) u_rr (
    .req (req_valid),
    .ptr (ptr_reg),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign own_x  = req_x[owner_reg*K +: K];
  assign own_y  = req_y[owner_reg*K +: K];
  assign in_op  = (state_reg == LOAD) || (state_reg == DRAIN);
  assign accept = (state_reg == LOAD) && req_gnt_reg[owner_reg] && req_xy_valid[owner_reg];
  assign res_in = mm_valid && in_op;

  // Release is judged on the post-increment counts so the last operand and
  // the last result may land on the same edge.
  assign op_cnt_inc  = op_cnt_reg + CW'(accept);
  assign rs_cnt_inc  = rs_cnt_reg + CW'(res_in);
  assign release_now = in_op && (op_cnt_inc == N_CNT) && (rs_cnt_inc == N_CNT);

  always_comb begin
    op_cnt_next = op_cnt_inc;
    rs_cnt_next = rs_cnt_inc;
    if ((state_reg == IDLE) || release_now) begin
      op_cnt_next = '0;
      rs_cnt_next = '0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      owner_reg  <= '0;
      ptr_reg    <= '0;
      op_cnt_reg <= '0;
      rs_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      ptr_reg    <= ptr_next;
      op_cnt_reg <= op_cnt_next;
      rs_cnt_reg <= rs_cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (|arb_gnt) begin
          state_next = START;
          owner_next = arb_idx;
        end
      end
      START: state_next = LOAD;
      LOAD: begin
        if (release_now)               state_next = IDLE;
        else if (op_cnt_inc == N_CNT)  state_next = DRAIN;
      end
      DRAIN: begin
        if (release_now) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (release_now) ptr_next = OW'(rr_next(int'(owner_reg), R));
  end

  // Output logic: values every output register takes on the next edge.
  always_comb begin
    mm_start_next  = (state_next == START);
    busy_next      = (state_next != IDLE);
    req_gnt_next   = (state_next == LOAD) ? (R'(1) << owner_next) : '0;
    xy_valid_next  = accept;
    mm_x_next      = accept ? own_x : mm_x_reg;
    mm_y_next      = accept ? own_y : mm_y_reg;
    rsp_valid_next = res_in ? (R'(1) << owner_reg) : '0;
    rsp_data_next  = res_in ? mm_result : rsp_data_reg;
    rsp_last_next  = res_in && (rs_cnt_reg == N_M1);
    err_stray_next = mm_valid && !in_op;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mm_start_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      req_gnt_reg   <= '0;
      xy_valid_reg  <= 1'b0;
      mm_x_reg      <= '0;
      mm_y_reg      <= '0;
      rsp_valid_reg <= '0;
      rsp_data_reg  <= '0;
      rsp_last_reg  <= 1'b0;
      err_stray_reg <= 1'b0;
    end else begin
      mm_start_reg  <= mm_start_next;
      busy_reg      <= busy_next;
      req_gnt_reg   <= req_gnt_next;
      xy_valid_reg  <= xy_valid_next;
      mm_x_reg      <= mm_x_next;
      mm_y_reg      <= mm_y_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_last_reg  <= rsp_last_next;
      err_stray_reg <= err_stray_next;
    end
  end

  assign mm_start   = mm_start_reg;
  assign busy       = busy_reg;
  assign owner      = owner_reg;
  assign req_gnt    = req_gnt_reg;
  assign mm_x       = mm_x_reg;
  assign mm_y       = mm_y_reg;
  assign mm_x_valid = xy_valid_reg;
  assign mm_y_valid = xy_valid_reg;
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_data   = rsp_data_reg;
  assign rsp_last   = rsp_last_reg;
  assign err_stray  = err_stray_reg;

endmodule
